// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory fetch controller:
// controller states, memory geometry and instruction constants.
package mips_pkg;

   localparam int          IM_ADDR_W = 6;
   localparam int          INSTR_W   = 32;
   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP       = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   // Force a byte address onto a word boundary.
   function automatic logic [31:0] align_word(input logic [31:0] byte_addr);
      return {byte_addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// Boot-time write sequencer: accepts program words while enabled, steps the
// IM write address and counts stored words. Flags the final accepted word.
module imem_boot_loader
   import mips_pkg::*;
#(
   parameter int ADDR_W = IM_ADDR_W
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              ld_valid,
   input  logic              ld_last,
   output logic [ADDR_W-1:0] waddr,
   output logic [ADDR_W:0]   ld_count,
   output logic              accept,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
   localparam logic [ADDR_W:0]   MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W-1:0] waddr_r;
   logic [ADDR_W:0]   count_r;

   // A word is taken whenever the loader offers one while enabled; the image
   // ends on an explicit last flag or when the top word of IM has been filled.
   always_comb begin
      accept = en & ld_valid;
      done   = accept & (ld_last | (waddr_r == LAST_ADDR));
   end

   // Advance the write pointer and the saturating word counter per accepted word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         waddr_r <= '0;
         count_r <= '0;
      end else if (accept) begin
         waddr_r <= waddr_r + 1'b1;
         if (count_r != MAX_COUNT) begin
            count_r <= count_r + 1'b1;
         end else begin
            count_r <= count_r;
         end
      end else begin
         waddr_r <= waddr_r;
         count_r <= count_r;
      end
   end

   assign waddr    = waddr_r;
   assign ld_count = count_r;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: loads the program image in BOOT, then fetches
// one instruction per cycle into the IF/ID register in RUN until a halt
// sentinel is read. HALT is left only through reset.
module imem_fetch_ctrl
   import mips_pkg::*;
#(
   parameter int                ADDR_W    = IM_ADDR_W,
   parameter int                DATA_W    = INSTR_W,
   parameter logic [31:0]       RESET_PC  = 32'h0000_0000,
   parameter logic [DATA_W-1:0] HALT_WORD = mips_pkg::HALT_WORD
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic [ADDR_W-1:0] imem_raddr,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_instr,
   output logic [31:0]       if_pc,
   output logic              halted,
   output logic              align_err,
   output logic [ADDR_W:0]   ld_count
);

   fetch_state_e      state_r,     state_n;
   logic [31:0]       pc_r,        pc_n;
   logic              if_valid_r,  if_valid_n;
   logic [DATA_W-1:0] if_instr_r,  if_instr_n;
   logic [31:0]       if_pc_r,     if_pc_n;
   logic              halted_r,    halted_n;
   logic              align_err_r, align_err_n;

   logic              boot_s;
   logic              ld_accept_s;
   logic              ld_done_s;
   logic [ADDR_W-1:0] ld_waddr_s;

   assign boot_s = (state_r == BOOT);

   imem_boot_loader #(
      .ADDR_W (ADDR_W)
   ) u_boot_loader (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (boot_s),
      .ld_valid (ld_valid),
      .ld_last  (ld_last),
      .waddr    (ld_waddr_s),
      .ld_count (ld_count),
      .accept   (ld_accept_s),
      .done     (ld_done_s)
   );

   // Loader handshake and IM write port: open only during BOOT, data passes straight through.
   always_comb begin
      ld_ready   = boot_s;
      imem_we    = ld_accept_s;
      imem_waddr = ld_waddr_s;
      imem_wdata = ld_data;
      imem_raddr = pc_r[ADDR_W+1:2];
   end

   // Next-state logic: BOOT waits for the image to finish; RUN fetches, honours
   // redirect over stall and stops on the sentinel; HALT freezes everything.
   always_comb begin
      state_n     = state_r;
      pc_n        = pc_r;
      if_valid_n  = if_valid_r;
      if_instr_n  = if_instr_r;
      if_pc_n     = if_pc_r;
      halted_n    = halted_r;
      align_err_n = align_err_r;
      case (state_r)
         BOOT: begin
            if_valid_n = 1'b0;
            if (ld_done_s) begin
               state_n = RUN;
               pc_n    = RESET_PC;
            end else begin
               state_n = BOOT;
            end
         end
         RUN: begin
            if (redirect) begin
               pc_n       = align_word(redirect_pc);
               if_valid_n = 1'b0;
               if (redirect_pc[1:0] != 2'b00) begin
                  align_err_n = 1'b1;
               end else begin
                  align_err_n = align_err_r;
               end
            end else if (stall) begin
               pc_n = pc_r;
            end else if (imem_rdata == HALT_WORD) begin
               // The sentinel is consumed here and never reaches IF/ID.
               state_n    = HALT;
               halted_n   = 1'b1;
               if_valid_n = 1'b0;
            end else begin
               if_instr_n = imem_rdata;
               if_pc_n    = pc_r;
               if_valid_n = 1'b1;
               pc_n       = pc_r + 32'd4;
            end
         end
         HALT: begin
            state_n    = HALT;
            if_valid_n = 1'b0;
         end
         default: begin
            state_n    = BOOT;
            if_valid_n = 1'b0;
         end
      endcase
   end

   // State and IF/ID registers; reset abandons any load or fetch in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= BOOT;
         pc_r        <= RESET_PC;
         if_valid_r  <= 1'b0;
         if_instr_r  <= DATA_W'(NOP);
         if_pc_r     <= 32'h0000_0000;
         halted_r    <= 1'b0;
         align_err_r <= 1'b0;
      end else begin
         state_r     <= state_n;
         pc_r        <= pc_n;
         if_valid_r  <= if_valid_n;
         if_instr_r  <= if_instr_n;
         if_pc_r     <= if_pc_n;
         halted_r    <= halted_n;
         align_err_r <= align_err_n;
      end
   end

   assign if_valid  = if_valid_r;
   assign if_instr  = if_instr_r;
   assign if_pc     = if_pc_r;
   assign halted    = halted_r;
   assign align_err = align_err_r;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural 64-word IM attached.
module tb_imem_fetch_ctrl;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ld_valid;
   logic              ld_ready;
   logic [DATA_W-1:0] ld_data;
   logic              ld_last;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [DATA_W-1:0] imem_wdata;
   logic [ADDR_W-1:0] imem_raddr;
   logic [DATA_W-1:0] imem_rdata;
   logic              stall;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic              if_valid;
   logic [DATA_W-1:0] if_instr;
   logic [31:0]       if_pc;
   logic              halted;
   logic              align_err;
   logic [ADDR_W:0]   ld_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [DATA_W-1:0] im [0:63] = '{default: 32'h0000_0000};

   imem_fetch_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .imem_we     (imem_we),
      .imem_waddr  (imem_waddr),
      .imem_wdata  (imem_wdata),
      .imem_raddr  (imem_raddr),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .halted      (halted),
      .align_err   (align_err),
      .ld_count    (ld_count)
   );

   always #5 clk = ~clk;

   // IM model: synchronous write, combinational read.
   always @(posedge clk) begin
      if (imem_we) im[imem_waddr] <= imem_wdata;
   end
   assign imem_rdata = im[imem_raddr];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; ld_valid = 1'b0; ld_data = 32'h0; ld_last = 1'b0;
      stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check_val("rst_ld_ready", 32'(ld_ready), 32'd1);
      check_val("rst_if_valid", 32'(if_valid), 32'd0);
      check_val("rst_halted", 32'(halted), 32'd0);
      check_val("rst_align_err", 32'(align_err), 32'd0);
      check_val("rst_ld_count", 32'(ld_count), 32'd0);
      check_val("rst_if_pc", if_pc, 32'h0);
      check_val("rst_if_instr", if_instr, 32'h0);

      // 64-word image without ld_last: automatic switch to RUN after word 63
      for (int i = 0; i < 64; i++) begin
         ld_valid = 1'b1;
         ld_data  = 32'hA000_0000 + 32'(i);
         ld_last  = 1'b0;
         #1;
         if (i == 0 || i == 63) begin
            check_val("t2_we", 32'(imem_we), 32'd1);
            check_val("t2_waddr", 32'(imem_waddr), 32'(i));
         end
         tick();
      end
      #1;
      check_val("t2_ready_off", 32'(ld_ready), 32'd0);
      check_val("t2_we_off", 32'(imem_we), 32'd0);
      check_val("t2_count64", 32'(ld_count), 32'd64);
      check_val("t2_no_valid_yet", 32'(if_valid), 32'd0);
      check_val("t2_raddr0", 32'(imem_raddr), 32'd0);

      // fetch stream with a two-cycle stall
      tick();
      check_val("t3_v0", 32'(if_valid), 32'd1);
      check_val("t3_i0", if_instr, 32'hA000_0000);
      check_val("t3_p0", if_pc, 32'h0);
      tick();
      check_val("t3_i1", if_instr, 32'hA000_0001);
      check_val("t3_p1", if_pc, 32'h4);
      stall = 1'b1;
      tick();
      check_val("t3_stall1_i", if_instr, 32'hA000_0001);
      tick();
      check_val("t3_stall2_i", if_instr, 32'hA000_0001);
      check_val("t3_stall2_p", if_pc, 32'h4);
      check_val("t3_stall2_v", 32'(if_valid), 32'd1);
      stall = 1'b0;
      tick();
      check_val("t3_i2", if_instr, 32'hA000_0002);
      check_val("t3_p2", if_pc, 32'h8);
      check_val("t3_count_held", 32'(ld_count), 32'd64);

      // redirect wins over stall
      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0010;
      tick();
      check_val("t4_squash", 32'(if_valid), 32'd0);
      check_val("t4_raddr", 32'(imem_raddr), 32'd4);
      check_val("t4_pc_kept", if_pc, 32'h8);
      check_val("t4_instr_kept", if_instr, 32'hA000_0002);
      stall = 1'b0; redirect = 1'b0;
      tick();
      check_val("t4_i", if_instr, 32'hA000_0004);
      check_val("t4_p", if_pc, 32'h10);
      check_val("t4_v", 32'(if_valid), 32'd1);

      // misaligned redirect, then wrap from the top word
      redirect = 1'b1; redirect_pc = 32'h0000_0013;
      tick();
      check_val("t5_raddr", 32'(imem_raddr), 32'd4);
      check_val("t5_align", 32'(align_err), 32'd1);
      redirect_pc = 32'h0000_00FC;
      tick();
      check_val("t5_raddr63", 32'(imem_raddr), 32'd63);
      redirect = 1'b0; ld_valid = 1'b0;
      tick();
      check_val("t5_i63", if_instr, 32'hA000_003F);
      check_val("t5_p63", if_pc, 32'h0000_00FC);
      check_val("t5_wrap", 32'(imem_raddr), 32'd0);
      check_val("t5_sticky", 32'(align_err), 32'd1);

      // reset mid-RUN, then a 3-word image with ld_last on the third
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_val("t1_rst_count", 32'(ld_count), 32'd0);
      check_val("t1_rst_align", 32'(align_err), 32'd0);
      for (int k = 0; k < 3; k++) begin
         ld_valid = 1'b1;
         ld_data  = 32'h2400_0000 + 32'(k);
         ld_last  = (k == 2);
         #1;
         check_val("t1_we", 32'(imem_we), 32'd1);
         check_val("t1_waddr", 32'(imem_waddr), 32'(k));
         tick();
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      #1;
      check_val("t1_count3", 32'(ld_count), 32'd3);
      check_val("t1_run_ready", 32'(ld_ready), 32'd0);
      tick();
      check_val("t1_i0", if_instr, 32'h2400_0000);
      check_val("t1_v0", 32'(if_valid), 32'd1);

      // halt sentinel at word 3
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ld_valid = 1'b1;
         ld_data  = (k == 3) ? 32'hFFFF_FFFF : 32'h3000_0000 + 32'(k);
         ld_last  = (k == 3);
         tick();
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      tick();
      tick();
      tick();
      check_val("t6_p8", if_pc, 32'h8);
      check_val("t6_i2", if_instr, 32'h3000_0002);
      tick();
      check_val("t6_halted", 32'(halted), 32'd1);
      check_val("t6_no_valid", 32'(if_valid), 32'd0);
      check_val("t6_pc_frozen", if_pc, 32'h8);
      check_val("t6_raddr", 32'(imem_raddr), 32'd3);
      redirect = 1'b1; redirect_pc = 32'h0000_0021; ld_valid = 1'b1;
      tick();
      check_val("t6_hold_raddr", 32'(imem_raddr), 32'd3);
      check_val("t6_hold_align", 32'(align_err), 32'd0);
      check_val("t6_hold_ready", 32'(ld_ready), 32'd0);
      check_val("t6_hold_we", 32'(imem_we), 32'd0);
      check_val("t6_hold_halted", 32'(halted), 32'd1);
      redirect = 1'b0; ld_valid = 1'b0; rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_val("t6_rst_halted", 32'(halted), 32'd0);
      check_val("t6_rst_count", 32'(ld_count), 32'd0);
      check_val("t6_rst_ready", 32'(ld_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
